// File: rtl/dl_fifo.sv
// dl_fifo: elastic data latch for the multi-cycle datapath.
//
// Holds up to DEPTH words of WIDTH bits in arrival order, with a valid/ready handshake on
// both sides. It replaces the single-register DR/A/B/ALUOut buffer and adds back-pressure,
// flush and occupancy reporting.
//
// Ports:
//   clk        in   sole clock, all state changes on its rising edge
//   rst        in   asynchronous active-low reset
//   flush      in   synchronous clear, active-high, overrides push and pop
//   in_valid   in   producer presents a word on in_data
//   in_data    in   word to store
//   in_ready   out  a word can be accepted this cycle (not full)
//   out_valid  out  out_data holds the oldest stored word (not empty)
//   out_data   out  oldest stored word, or RESET_VAL when empty
//   out_ready  in   consumer takes the word this cycle
//   count      out  number of stored words, 0..DEPTH
//
// All outputs are decoded from registers only; out_ready never reaches in_ready, so a full
// buffer refuses a push even when a pop happens on the same edge.
module dl_fifo #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 2,
  parameter logic [63:0] RESET_VAL = 64'h0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic                         in_valid,
  input  logic [WIDTH-1:0]             in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  output logic [WIDTH-1:0]             out_data,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  localparam logic [WIDTH-1:0] ResetWord = RESET_VAL[WIDTH-1:0];
  localparam logic [PtrW-1:0]  PtrLast   = PtrW'(DEPTH - 1);
  localparam logic [CntW-1:0]  CntFull   = CntW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PtrW-1:0]  wp_q, wp_d;
  logic [PtrW-1:0]  rp_q, rp_d;
  logic [CntW-1:0]  count_q, count_d;

  logic push, pop;

  // DEPTH need not be a power of two, so wrap on an explicit compare.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrLast) ? '0 : p + PtrW'(1);
  endfunction

  // Handshake qualification uses registered status only.
  always_comb begin
    push = in_valid & (count_q != CntFull);
    pop  = out_ready & (count_q != '0);
  end

  always_comb begin
    mem_d   = mem_q;
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;

    if (flush) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_d[i] = ResetWord;
      end
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        mem_d[wp_q] = in_data;
        wp_d        = ptr_inc(wp_q);
      end
      if (pop) begin
        rp_d = ptr_inc(rp_q);
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= ResetWord;
      end
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  // Popped entries keep stale data, so the empty case is masked explicitly.
  always_comb begin
    in_ready  = (count_q != CntFull);
    out_valid = (count_q != '0);
    out_data  = out_valid ? mem_q[rp_q] : ResetWord;
    count     = count_q;
  end

endmodule

// File: tb/tb_dl_fifo.sv
// Bench for dl_fifo: three instances (32x2 default, 32x3, 8x1) share one stimulus stream.
// A queue per instance holds the words it should emit; each cycle the outputs are compared
// against the queue front and the occupancy implied by the queue, and a vector table adds
// hand-derived counts per row.
module tb_dl_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = 32'h0;
  logic        out_ready = 1'b0;

  logic        ir2, ov2, ir3, ov3, ir1, ov1;
  logic [31:0] od2, od3;
  logic [7:0]  od1;
  logic [1:0]  cnt2, cnt3;
  logic [0:0]  cnt1;

  int ncheck = 0;
  int nfail  = 0;

  logic [31:0] q2[$];
  logic [31:0] q3[$];
  logic [31:0] q1[$];

  localparam logic [31:0] Rv2 = 32'h0;
  localparam logic [31:0] Rv3 = 32'hC0DE0000;
  localparam logic [31:0] Rv1 = 32'h3C;

  always #5 clk = ~clk;

  dl_fifo #(.WIDTH(32), .DEPTH(2), .RESET_VAL(64'h0)) u_d2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir2), .out_valid(ov2), .out_data(od2), .out_ready(out_ready), .count(cnt2)
  );

  dl_fifo #(.WIDTH(32), .DEPTH(3), .RESET_VAL(64'hC0DE0000)) u_d3 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data),
    .in_ready(ir3), .out_valid(ov3), .out_data(od3), .out_ready(out_ready), .count(cnt3)
  );

  dl_fifo #(.WIDTH(8), .DEPTH(1), .RESET_VAL(64'h3C)) u_d1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_data(in_data[7:0]),
    .in_ready(ir1), .out_valid(ov1), .out_data(od1), .out_ready(out_ready), .count(cnt1)
  );

  typedef struct {
    logic        v;
    logic [31:0] d;
    logic        r;
    logic        f;
    int          c2;
    int          c1;
    int          c3;
  } vec_t;

  vec_t tbl[28];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ncheck++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  task automatic check_model(input string tag);
    #1;
    chk({tag, " d2 count"}, 64'(cnt2), 64'(q2.size()));
    chk({tag, " d2 in_ready"}, 64'(ir2), 64'(q2.size() != 2));
    chk({tag, " d2 out_valid"}, 64'(ov2), 64'(q2.size() != 0));
    chk({tag, " d2 out_data"}, 64'(od2), 64'((q2.size() != 0) ? q2[0] : Rv2));
    chk({tag, " d3 count"}, 64'(cnt3), 64'(q3.size()));
    chk({tag, " d3 in_ready"}, 64'(ir3), 64'(q3.size() != 3));
    chk({tag, " d3 out_valid"}, 64'(ov3), 64'(q3.size() != 0));
    chk({tag, " d3 out_data"}, 64'(od3), 64'((q3.size() != 0) ? q3[0] : Rv3));
    chk({tag, " d1 count"}, 64'(cnt1), 64'(q1.size()));
    chk({tag, " d1 in_ready"}, 64'(ir1), 64'(q1.size() != 1));
    chk({tag, " d1 out_valid"}, 64'(ov1), 64'(q1.size() != 0));
    chk({tag, " d1 out_data"}, 64'(od1), 64'((q1.size() != 0) ? q1[0] : Rv1));
  endtask

  // Clock one edge and update the expected queues with what that edge should do.
  task automatic advance();
    logic ps, pp;
    @(posedge clk);
    if (!rst || flush) begin
      q2.delete();
      q3.delete();
      q1.delete();
    end else begin
      ps = in_valid && (q2.size() < 2);
      pp = out_ready && (q2.size() > 0);
      if (pp) void'(q2.pop_front());
      if (ps) q2.push_back(in_data);
      ps = in_valid && (q3.size() < 3);
      pp = out_ready && (q3.size() > 0);
      if (pp) void'(q3.pop_front());
      if (ps) q3.push_back(in_data);
      ps = in_valid && (q1.size() < 1);
      pp = out_ready && (q1.size() > 0);
      if (pp) void'(q1.pop_front());
      if (ps) q1.push_back({24'h0, in_data[7:0]});
    end
    @(negedge clk);
  endtask

  initial begin
    // {v, d, r, f, count before edge for DEPTH=2, DEPTH=1, DEPTH=3}
    tbl[0]  = '{1'b1, 32'hA5A5A5A5, 1'b0, 1'b0, 0, 0, 0};
    tbl[1]  = '{1'b1, 32'h5A5A5A5A, 1'b0, 1'b0, 1, 1, 1};
    tbl[2]  = '{1'b1, 32'hFFFFFFFF, 1'b0, 1'b0, 2, 1, 2};
    tbl[3]  = '{1'b0, 32'h0,        1'b1, 1'b0, 2, 1, 3};
    tbl[4]  = '{1'b0, 32'h0,        1'b1, 1'b0, 1, 0, 2};
    tbl[5]  = '{1'b0, 32'h0,        1'b0, 1'b0, 0, 0, 1};
    tbl[6]  = '{1'b1, 32'h77,       1'b0, 1'b0, 0, 0, 1};
    tbl[7]  = '{1'b1, 32'h1,        1'b1, 1'b0, 1, 1, 2};
    tbl[8]  = '{1'b1, 32'h2,        1'b1, 1'b0, 1, 0, 2};
    tbl[9]  = '{1'b1, 32'h3,        1'b1, 1'b0, 1, 1, 2};
    tbl[10] = '{1'b1, 32'h4,        1'b1, 1'b0, 1, 0, 2};
    tbl[11] = '{1'b0, 32'h0,        1'b0, 1'b0, 1, 1, 2};
    tbl[12] = '{1'b1, 32'h5,        1'b0, 1'b0, 1, 1, 2};
    tbl[13] = '{1'b1, 32'h6,        1'b1, 1'b0, 2, 1, 3};
    tbl[14] = '{1'b0, 32'h0,        1'b0, 1'b0, 1, 0, 2};
    tbl[15] = '{1'b1, 32'h8,        1'b0, 1'b0, 1, 0, 2};
    tbl[16] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 2, 1, 3};
    tbl[17] = '{1'b0, 32'h0,        1'b1, 1'b0, 0, 0, 0};
    tbl[18] = '{1'b1, 32'h10,       1'b0, 1'b0, 0, 0, 0};
    tbl[19] = '{1'b1, 32'h11,       1'b1, 1'b0, 1, 1, 1};
    tbl[20] = '{1'b1, 32'h12,       1'b1, 1'b0, 1, 0, 1};
    tbl[21] = '{1'b1, 32'h13,       1'b0, 1'b0, 1, 1, 1};
    tbl[22] = '{1'b1, 32'h14,       1'b1, 1'b0, 2, 1, 2};
    tbl[23] = '{1'b1, 32'h15,       1'b1, 1'b0, 1, 0, 2};
    tbl[24] = '{1'b1, 32'h16,       1'b1, 1'b0, 1, 1, 2};
    tbl[25] = '{1'b0, 32'h0,        1'b1, 1'b0, 1, 0, 2};
    tbl[26] = '{1'b0, 32'h0,        1'b1, 1'b0, 0, 0, 1};
    tbl[27] = '{1'b0, 32'h0,        1'b1, 1'b0, 0, 0, 0};

    // Reset state, before any clock edge.
    #1;
    chk("reset d2 in_ready", 64'(ir2), 64'h1);
    chk("reset d2 out_valid", 64'(ov2), 64'h0);
    chk("reset d2 out_data", 64'(od2), 64'h0);
    chk("reset d2 count", 64'(cnt2), 64'h0);
    chk("reset d3 out_data", 64'(od3), 64'hC0DE0000);
    chk("reset d1 out_data", 64'(od1), 64'h3C);
    #1 rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 28; i++) begin
      drive(tbl[i].v, tbl[i].d, tbl[i].r, tbl[i].f);
      check_model($sformatf("row%0d", i));
      chk($sformatf("row%0d tbl d2 count", i), 64'(cnt2), 64'(tbl[i].c2));
      chk($sformatf("row%0d tbl d1 count", i), 64'(cnt1), 64'(tbl[i].c1));
      chk($sformatf("row%0d tbl d3 count", i), 64'(cnt3), 64'(tbl[i].c3));
      advance();
    end

    // Asynchronous reset with the DEPTH=2 buffer full.
    drive(1'b1, 32'hAAAA0001, 1'b0, 1'b0);
    check_model("rst pre1");
    advance();
    drive(1'b1, 32'hAAAA0002, 1'b0, 1'b0);
    check_model("rst pre2");
    advance();
    chk("rst pre d2 full", 64'(cnt2), 64'h2);
    #2 rst = 1'b0;
    #1;
    chk("async rst d2 in_ready", 64'(ir2), 64'h1);
    chk("async rst d2 out_valid", 64'(ov2), 64'h0);
    chk("async rst d2 count", 64'(cnt2), 64'h0);
    chk("async rst d2 out_data", 64'(od2), 64'h0);
    chk("async rst d1 out_data", 64'(od1), 64'h3C);
    q2.delete();
    q3.delete();
    q1.delete();
    @(negedge clk);
    drive(1'b1, 32'hBBBB0000, 1'b1, 1'b0);
    check_model("rst held");
    advance();
    check_model("rst held after edge");
    rst = 1'b1;
    drive(1'b1, 32'h12345678, 1'b0, 1'b0);
    check_model("rst release push");
    advance();
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_model("rst release out");
    chk("rst release d2 data", 64'(od2), 64'h12345678);
    advance();

    // Drain, then DEPTH=1 with both sides active: one word per two cycles.
    drive(1'b0, 32'h0, 1'b1, 1'b0);
    check_model("drain");
    advance();
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 32'h50 + 32'(i), 1'b1, 1'b0);
      check_model($sformatf("alt%0d", i));
      chk($sformatf("alt%0d d1 count", i), 64'(cnt1), 64'(i % 2));
      chk($sformatf("alt%0d d1 in_ready", i), 64'(ir1), 64'((i % 2) == 0));
      advance();
    end
    drive(1'b0, 32'h0, 1'b0, 1'b0);
    check_model("final");

    $display("TB_RESULT checks=%0d failures=%0d", ncheck, nfail);
    $finish;
  end

endmodule
